// File: rtl/md_issue.sv
// Issue/write-back controller for the iterative mult/div unit: starts the unit, tracks its latency,
// applies sign correction and owns HI/LO. Define MD_SIGNED_EN to enable signed MULT/DIV handling.
module md_issue #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        md_valid_E,
  input  logic [2:0]  md_op_E,
  input  logic [31:0] rs_val_E,
  input  logic [31:0] rt_val_E,
  input  logic        md_use_D,
  output logic        stall_D,
  output logic        u_start,
  output logic        u_mult,
  output logic        u_div,
  output logic [31:0] u_data1,
  output logic [31:0] u_data2,
  input  logic [31:0] u_hi,
  input  logic [31:0] u_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_busy
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      hi_q, lo_q;
  logic [31:0]      fix_hi_d, fix_lo_d;
  logic             idle, is_mul, is_div, issue;

  assign idle   = (state_q == IDLE);
  assign is_mul = (md_op_E == OP_MULT) || (md_op_E == OP_MULTU);
  // A zero divisor never starts the unit, so HI/LO keep their old values.
  assign is_div = ((md_op_E == OP_DIV) || (md_op_E == OP_DIVU)) && (rt_val_E != 32'd0);
  assign issue  = md_valid_E & idle & (is_mul | is_div);

  assign u_start = issue;
  assign u_mult  = issue & is_mul;
  assign u_div   = issue & is_div;
  assign md_busy = ~idle;
  assign stall_D = md_use_D & (md_busy | issue);
  assign hi      = hi_q;
  assign lo      = lo_q;

`ifdef MD_SIGNED_EN
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  logic div_q, neg_lo_q, neg_hi_q;
  logic signed_op, neg_lo_d, neg_hi_d;

  assign signed_op = (md_op_E == OP_MULT) || (md_op_E == OP_DIV);
  assign neg_lo_d  = signed_op & (rs_val_E[31] ^ rt_val_E[31]);
  // Remainder takes the dividend's sign; a product negates both halves together.
  assign neg_hi_d  = signed_op & ((md_op_E == OP_MULT) ? (rs_val_E[31] ^ rt_val_E[31])
                                                       : rs_val_E[31]);
  assign u_data1   = signed_op ? mag32(rs_val_E) : rs_val_E;
  assign u_data2   = signed_op ? mag32(rt_val_E) : rt_val_E;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else if (issue) begin
      div_q    <= is_div;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
    end
  end

  always_comb begin
    fix_hi_d = u_hi;
    fix_lo_d = u_lo;
    if (div_q) begin
      if (neg_lo_q) fix_lo_d = mag32(~u_lo + 32'd1) == 32'd0 ? 32'd0 : (~u_lo + 32'd1);
      if (neg_hi_q) fix_hi_d = ~u_hi + 32'd1;
    end else if (neg_lo_q) begin
      {fix_hi_d, fix_lo_d} = neg64({u_hi, u_lo});
    end
  end
`else
  assign u_data1  = rs_val_E;
  assign u_data2  = rt_val_E;
  assign fix_hi_d = u_hi;
  assign fix_lo_d = u_lo;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue) begin
            cnt_q   <= is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            state_q <= RUN;
          end else if (md_valid_E && (md_op_E == OP_MTHI)) begin
            hi_q <= rs_val_E;
          end else if (md_valid_E && (md_op_E == OP_MTLO)) begin
            lo_q <= rs_val_E;
          end
        end
        // cnt reaches zero on the edge that enters FIX; unit results are valid during FIX.
        RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= fix_hi_d;
          lo_q    <= fix_lo_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_issue.sv
// Directed, table-driven bench for md_issue with a latency-accurate model of the mult/div unit.
module tb_md_issue;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        md_valid_E = 1'b0;
  logic [2:0]  md_op_E = 3'd0;
  logic [31:0] rs_val_E = 32'd0;
  logic [31:0] rt_val_E = 32'd0;
  logic        md_use_D = 1'b0;
  logic        stall_D, u_start, u_mult, u_div, md_busy;
  logic [31:0] u_data1, u_data2, u_hi, u_lo, hi, lo;

  int total = 0;
  int bad   = 0;

  md_issue #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .md_valid_E(md_valid_E), .md_op_E(md_op_E),
    .rs_val_E(rs_val_E), .rt_val_E(rt_val_E), .md_use_D(md_use_D), .stall_D(stall_D),
    .u_start(u_start), .u_mult(u_mult), .u_div(u_div), .u_data1(u_data1), .u_data2(u_data2),
    .u_hi(u_hi), .u_lo(u_lo), .hi(hi), .lo(lo), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  // Unit model: results appear exactly LAT edges after the start edge, garbage before that.
  logic [31:0] m_a = 32'd0, m_b = 32'd0;
  logic        m_div = 1'b0, m_have = 1'b0;
  int          m_rem = 0;
  logic [63:0] m_prod;

  always @(posedge clk) begin
    if (u_start) begin
      m_a    <= u_data1;
      m_b    <= u_data2;
      m_div  <= u_div;
      m_have <= 1'b1;
      m_rem  <= u_div ? DIV_LAT : MULT_LAT;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
    end
  end

  always_comb begin
    m_prod = {32'd0, m_a} * {32'd0, m_b};
    u_hi   = 32'hDEADBEEF;
    u_lo   = 32'hBADC0FFE;
    if (m_have && (m_rem == 0)) begin
      if (m_div) begin
        u_hi = (m_b != 32'd0) ? (m_a % m_b) : 32'd0;
        u_lo = (m_b != 32'd0) ? (m_a / m_b) : 32'd0;
      end else begin
        u_hi = m_prod[63:32];
        u_lo = m_prod[31:0];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // kind: 0 = no unit start, 1 = multiply, 2 = divide
  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          kind;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vt[13];

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    @(negedge clk);
    md_valid_E = 1'b1;
    md_op_E    = v.op;
    rs_val_E   = v.rs;
    rt_val_E   = v.rt;
    #1;
    chk($sformatf("v%0d u_start", idx), 64'(u_start), 64'(v.kind != 0));
    chk($sformatf("v%0d u_mult", idx), 64'(u_mult), 64'(v.kind == 1));
    chk($sformatf("v%0d u_div", idx), 64'(u_div), 64'(v.kind == 2));
    if (v.kind != 0) begin
      chk($sformatf("v%0d u_data1", idx), 64'(u_data1), 64'(v.d1));
      chk($sformatf("v%0d u_data2", idx), 64'(u_data2), 64'(v.d2));
    end
    @(negedge clk);
    md_valid_E = 1'b0;
    md_op_E    = 3'd0;
    n = 0;
    while (md_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("v%0d latency", idx), 64'(n),
        64'((v.kind == 1) ? MULT_LAT + 1 : (v.kind == 2) ? DIV_LAT + 1 : 0));
    chk($sformatf("v%0d hi", idx), 64'(hi), 64'(v.hi));
    chk($sformatf("v%0d lo", idx), 64'(lo), 64'(v.lo));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{3'd5, 32'h11112222, 32'h0, 0, 32'h0, 32'h0, 32'h11112222, 32'h0};
    vt[1] = '{3'd6, 32'h00001234, 32'h0, 0, 32'h0, 32'h0, 32'h11112222, 32'h00001234};
`ifdef MD_SIGNED_EN
    vt[2] = '{3'd1, 32'hFFFFFFFD, 32'd5, 1, 32'd3, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1};
`else
    vt[2] = '{3'd1, 32'hFFFFFFFD, 32'd5, 1, 32'hFFFFFFFD, 32'd5, 32'h4, 32'hFFFFFFF1};
`endif
    vt[3] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1};
`ifdef MD_SIGNED_EN
    vt[4] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'd1, 32'd1, 32'h0, 32'h1};
    vt[5] = '{3'd3, 32'hFFFFFFF9, 32'd2, 2, 32'd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
`else
    vt[4] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1};
    vt[5] = '{3'd3, 32'hFFFFFFF9, 32'd2, 2, 32'hFFFFFFF9, 32'd2, 32'h1, 32'h7FFFFFFC};
`endif
    vt[6] = '{3'd4, 32'hFFFFFFF9, 32'd2, 2, 32'hFFFFFFF9, 32'd2, 32'h1, 32'h7FFFFFFC};
    vt[7] = '{3'd4, 32'h00000064, 32'd0, 0, 32'h0, 32'h0, 32'h1, 32'h7FFFFFFC};
`ifdef MD_SIGNED_EN
    vt[8]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 2, 32'h80000000, 32'd1, 32'h0, 32'h80000000};
    vt[9]  = '{3'd3, 32'd7, 32'hFFFFFFFE, 2, 32'd7, 32'd2, 32'h1, 32'hFFFFFFFD};
    vt[10] = '{3'd1, 32'd7, 32'hFFFFFFFE, 1, 32'd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFF2};
    vt[11] = '{3'd7, 32'h55555555, 32'd3, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF2};
    vt[12] = '{3'd3, 32'hFFFFFFF0, 32'd0, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF2};
`else
    vt[8]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0};
    vt[9]  = '{3'd3, 32'd7, 32'hFFFFFFFE, 2, 32'd7, 32'hFFFFFFFE, 32'h7, 32'h0};
    vt[10] = '{3'd1, 32'd7, 32'hFFFFFFFE, 1, 32'd7, 32'hFFFFFFFE, 32'h6, 32'hFFFFFFF2};
    vt[11] = '{3'd7, 32'h55555555, 32'd3, 0, 32'h0, 32'h0, 32'h6, 32'hFFFFFFF2};
    vt[12] = '{3'd3, 32'hFFFFFFF0, 32'd0, 0, 32'h0, 32'h0, 32'h6, 32'hFFFFFFF2};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst hi", 64'(hi), 64'h0);
    chk("rst lo", 64'(lo), 64'h0);
    chk("rst busy", 64'(md_busy), 64'h0);
    chk("rst stall", 64'(stall_D), 64'h0);
    chk("rst u_start", 64'(u_start), 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(i, vt[i]);

    // MFHI held in D across a MULTU: stall from issue cycle through the FIX cycle
    @(negedge clk);
    md_use_D   = 1'b1;
    md_valid_E = 1'b1;
    md_op_E    = 3'd2;
    rs_val_E   = 32'd2;
    rt_val_E   = 32'd3;
    #1 chk("stall issue", 64'(stall_D), 64'h1);
    @(negedge clk);
    md_valid_E = 1'b0;
    md_op_E    = 3'd0;
    chk("stall e0", 64'(stall_D), 64'h1);
    for (int k = 1; k <= MULT_LAT; k++) begin
      @(negedge clk);
      chk($sformatf("stall e%0d", k), 64'(stall_D), 64'h1);
      chk($sformatf("busy e%0d", k), 64'(md_busy), 64'h1);
    end
    @(negedge clk);
    chk("stall release", 64'(stall_D), 64'h0);
    chk("busy release", 64'(md_busy), 64'h0);
    chk("mul23 hi", 64'(hi), 64'h0);
    chk("mul23 lo", 64'(lo), 64'h6);

    // MT with md_use_D in D: no stall, one-edge write latency
    md_valid_E = 1'b1;
    md_op_E    = 3'd6;
    rs_val_E   = 32'h1234;
    #1 chk("mt stall", 64'(stall_D), 64'h0);
    chk("mt lo before edge", 64'(lo), 64'h6);
    @(negedge clk);
    chk("mtlo lo", 64'(lo), 64'h1234);
    md_op_E  = 3'd5;
    rs_val_E = 32'hAAAA0000;
    @(negedge clk);
    chk("mthi hi", 64'(hi), 64'hAAAA0000);
    md_valid_E = 1'b0;
    md_op_E    = 3'd0;
    md_use_D   = 1'b0;

    // Reset during a DIVU: HI/LO clear immediately, late unit result never captured
    @(negedge clk);
    md_valid_E = 1'b1;
    md_op_E    = 3'd4;
    rs_val_E   = 32'd100;
    rt_val_E   = 32'd7;
    @(negedge clk);
    md_valid_E = 1'b0;
    md_op_E    = 3'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid rst hi", 64'(hi), 64'h0);
    chk("mid rst lo", 64'(lo), 64'h0);
    chk("mid rst busy", 64'(md_busy), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post rst hi", 64'(hi), 64'h0);
    chk("post rst lo", 64'(lo), 64'h0);
    chk("post rst busy", 64'(md_busy), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
